// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and receiver state encoding.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser on the serial pin plus a 3-sample majority filter.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rx_maj
);

  logic       sync1;
  logic [1:0] hist;

  // hist[0] is rx_s; rx_maj is registered so it covers rx_s and its two predecessors
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      hist   <= 2'b11;
      rx_maj <= 1'b1;
    end else begin
      sync1  <= rx;
      hist   <= {hist[0], sync1};
      rx_maj <= (sync1 & hist[0]) | (sync1 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign rx_s = hist[0];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable framing, glitch rejection, break
// detection and a valid/ack output with sticky overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);

  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_chk_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_sb
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic rx_s, rx_maj;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .rx_s   (rx_s),
    .rx_maj (rx_maj)
  );

  rx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 pbit, pbit_n;
  logic                 ferr, ferr_n;
  logic                 zero, zero_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 rx_valid_n, fe_n, pe_n, brk_n, overrun_n;
  logic                 sample, done_fe, done_brk, done_pe;

  always_comb begin
    state_n    = state;
    cnt_n      = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    idx_n      = idx;
    shreg_n    = shreg;
    pbit_n     = pbit;
    ferr_n     = ferr;
    zero_n     = zero;
    rx_data_n  = rx_data;
    rx_valid_n = rx_valid & ~rx_ack;
    fe_n       = frame_error;
    pe_n       = parity_error;
    brk_n      = break_det;
    overrun_n  = overrun & ~(rx_valid & rx_ack);
    sample     = (cnt == CNT_MID);
    done_fe    = ferr | ~rx_maj;
    // break looks only at the first stop bit
    done_brk   = (idx == '0) ? (zero & ~rx_maj) : zero;
    if (PARITY == PARITY_ODD)       done_pe = ~((^shreg) ^ pbit);
    else if (PARITY == PARITY_EVEN) done_pe = (^shreg) ^ pbit;
    else                            done_pe = 1'b0;

    case (state)
      ST_IDLE: begin
        // cnt is 0 on the first low cycle, so the start edge cycle counts as tick 0
        cnt_n = '0;
        if (!rx_s) begin
          state_n = ST_START;
          cnt_n   = CW'(1);
        end
      end
      ST_START: begin
        if (sample) begin
          if (rx_maj) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            idx_n   = '0;
            ferr_n  = 1'b0;
            zero_n  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_n = {rx_maj, shreg[DATA_BITS-1:1]};
          zero_n  = zero & ~rx_maj;
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          pbit_n  = rx_maj;
          zero_n  = zero & ~rx_maj;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          ferr_n = done_fe;
          zero_n = done_brk;
          if (idx == IW'(STOP_BITS - 1)) begin
            state_n = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            if (!rx_valid || rx_ack) begin
              rx_data_n  = shreg;
              fe_n       = done_fe;
              pe_n       = done_pe;
              brk_n      = done_brk;
              rx_valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      pbit         <= 1'b0;
      ferr         <= 1'b0;
      zero         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      break_det    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      pbit         <= pbit_n;
      ferr         <= ferr_n;
      zero         <= zero_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      frame_error  <= fe_n;
      parity_error <= pe_n;
      break_det    <= brk_n;
      overrun      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and an 8E1 receiver driven by a serial line model.
module tb_uart_rx_param;

  localparam int C       = 10;
  localparam int LAT_8N1 = 3 + C / 2 + 9 * C;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
  } word_t;

  logic       clk = 1'b0;
  logic       reset, rx_n, rx_e, ack_n, ack_e;
  logic [7:0] data_n, data_e;
  logic       valid_n, valid_e, fe_n, fe_e, pe_n, pe_e, brk_n, brk_e, ov_n, ov_e;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .reset(reset), .rx(rx_n), .rx_data(data_n), .rx_valid(valid_n), .rx_ack(ack_n),
    .frame_error(fe_n), .parity_error(pe_n), .break_det(brk_n), .overrun(ov_n));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .reset(reset), .rx(rx_e), .rx_data(data_e), .rx_valid(valid_e), .rx_ack(ack_e),
    .frame_error(fe_e), .parity_error(pe_e), .break_det(brk_e), .overrun(ov_e));

  // Expected word from the frame as sent on the wire (sel 1 = even-parity receiver)
  function automatic word_t model(input bit sel, input logic [7:0] d, input logic p, input logic stop);
    word_t w;
    w.data = d;
    w.fe   = ~stop;
    w.pe   = sel ? ((^d) ^ p) : 1'b0;
    w.brk  = (d == 8'h00) && (!sel || !p) && !stop;
    return w;
  endfunction

  function automatic word_t obs(input bit sel);
    return sel ? word_t'({data_e, fe_e, pe_e, brk_e}) : word_t'({data_n, fe_n, pe_n, brk_n});
  endfunction

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_e = v; else rx_n = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic p, input logic stop);
    logic [10:0] bits;
    int nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (sel) begin bits[9] = p; bits[10] = stop; nb = 11; end
    else begin bits[9] = stop; nb = 10; end
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      set_rx(sel, bits[i]);
      repeat (C) @(posedge clk);
      #1;
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic wait_valid(input bit sel, input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      got = sel ? valid_e : valid_n;
    end
  endtask

  task automatic pulse_ack(input bit sel);
    @(negedge clk);
    if (sel) ack_e = 1'b1; else ack_n = 1'b1;
    @(negedge clk);
    ack_e = 1'b0;
    ack_n = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_n = 1'b1; rx_e = 1'b1; ack_n = 1'b0; ack_e = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({data_n, valid_n, fe_n, pe_n, brk_n, ov_n} !== 13'd0) begin
      errors++; $display("FAIL reset_8n1: got %h expected 0", {data_n, valid_n, fe_n, pe_n, brk_n, ov_n});
    end
    checks++;
    if ({data_e, valid_e, fe_e, pe_e, brk_e, ov_e} !== 13'd0) begin
      errors++; $display("FAIL reset_8e1: got %h expected 0", {data_e, valid_e, fe_e, pe_e, brk_e, ov_e});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1_latency();
    logic [7:0] bytes [2];
    int n;
    bit got;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h3C;
    for (int b = 0; b < 2; b++) begin
      n = 0; got = 1'b0;
      fork
        send_frame(1'b0, bytes[b], 1'b0, 1'b1);
        begin
          @(posedge clk); #1;
          while (!got && n < 3 * LAT_8N1) begin
            @(posedge clk); #1;
            n++;
            got = valid_n;
          end
        end
      join
      checks++;
      if (n != LAT_8N1) begin errors++; $display("FAIL latency_8n1: got %0d edges expected %0d", n, LAT_8N1); end
      checks++;
      if (obs(1'b0) !== model(1'b0, bytes[b], 1'b0, 1'b1) || ov_n !== 1'b0) begin
        errors++; $display("FAIL word_8n1: got %h ov %b expected %h ov 0", obs(1'b0), ov_n, model(1'b0, bytes[b], 1'b0, 1'b1));
      end
      repeat ($urandom_range(1, 5)) @(negedge clk);
      pulse_ack(1'b0);
      checks++;
      if (valid_n !== 1'b0) begin errors++; $display("FAIL ack_clear_8n1: got valid %b expected 0", valid_n); end
    end
  endtask

  task automatic test_parity();
    logic pb [2];
    bit got;
    pb[0] = 1'b1;
    pb[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_frame(1'b1, 8'h3C, pb[i], 1'b1);
      wait_valid(1'b1, 2 * C, got);
      checks++;
      if (!got) begin errors++; $display("FAIL parity_valid: got no rx_valid expected 1"); end
      else if (obs(1'b1) !== model(1'b1, 8'h3C, pb[i], 1'b1)) begin
        errors++; $display("FAIL parity_word: got %h expected %h", obs(1'b1), model(1'b1, 8'h3C, pb[i], 1'b1));
      end
      pulse_ack(1'b1);
    end
  endtask

  task automatic test_frame_error();
    bit got;
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0);
    wait_valid(1'b0, 2 * C, got);
    checks++;
    if (!got || obs(1'b0) !== word_t'({8'hFF, 1'b1, 1'b0, 1'b0})) begin
      errors++; $display("FAIL frame_err: got %h valid %b expected %h", obs(1'b0), got, word_t'({8'hFF, 3'b100}));
    end
    pulse_ack(1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    wait_valid(1'b0, 2 * C, got);
    checks++;
    if (!got || obs(1'b0) !== model(1'b0, 8'h55, 1'b0, 1'b1)) begin
      errors++; $display("FAIL after_frame_err: got %h valid %b expected %h", obs(1'b0), got, model(1'b0, 8'h55, 1'b0, 1'b1));
    end
    pulse_ack(1'b0);
  endtask

  task automatic test_break();
    int words;
    word_t cap;
    words = 0;
    cap = '0;
    @(posedge clk); #1;
    rx_n = 1'b0;
    for (int i = 0; i < 25 * C; i++) begin
      if (i == 20 * C) rx_n = 1'b1;
      @(negedge clk);
      if (ack_n) ack_n = 1'b0;
      else if (valid_n) begin words++; cap = obs(1'b0); ack_n = 1'b1; end
    end
    ack_n = 1'b0;
    checks++;
    if (words != 1) begin errors++; $display("FAIL break_count: got %0d words expected 1", words); end
    checks++;
    if (cap !== word_t'({8'h00, 1'b1, 1'b0, 1'b1})) begin
      errors++; $display("FAIL break_word: got %h expected %h", cap, word_t'({8'h00, 3'b101}));
    end
  endtask

  task automatic test_glitch();
    int seen;
    bit got;
    seen = 0;
    @(posedge clk); #1;
    rx_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_n = 1'b1;
    for (int i = 0; i < 3 * C; i++) begin @(negedge clk); if (valid_n) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL glitch: got %0d valid cycles expected 0", seen); end
    send_frame(1'b0, 8'h96, 1'b0, 1'b1);
    wait_valid(1'b0, 2 * C, got);
    checks++;
    if (!got || obs(1'b0) !== model(1'b0, 8'h96, 1'b0, 1'b1)) begin
      errors++; $display("FAIL after_glitch: got %h valid %b expected %h", obs(1'b0), got, model(1'b0, 8'h96, 1'b0, 1'b1));
    end
    pulse_ack(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int seen;
    bit got;
    d = 8'h5A;
    seen = 0;
    @(posedge clk); #1;
    rx_n = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx_n = d[i];
      repeat ((i == 3) ? 3 : C) @(posedge clk);
      #1;
    end
    reset = 1'b1;
    rx_n  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4 * C; i++) begin @(negedge clk); if (valid_n) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid: got %0d valid cycles expected 0", seen); end
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    wait_valid(1'b0, 2 * C, got);
    checks++;
    if (!got || obs(1'b0) !== model(1'b0, 8'h81, 1'b0, 1'b1)) begin
      errors++; $display("FAIL after_reset_mid: got %h valid %b expected %h", obs(1'b0), got, model(1'b0, 8'h81, 1'b0, 1'b1));
    end
    pulse_ack(1'b0);
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (valid_n !== 1'b1 || data_n !== 8'h11 || ov_n !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got valid %b data %h ov %b expected 1 11 0", valid_n, data_n, ov_n);
    end
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (valid_n !== 1'b1 || data_n !== 8'h11 || ov_n !== 1'b1) begin
      errors++; $display("FAIL b2b_overrun: got valid %b data %h ov %b expected 1 11 1", valid_n, data_n, ov_n);
    end
    pulse_ack(1'b0);
    checks++;
    if (valid_n !== 1'b0 || ov_n !== 1'b0) begin
      errors++; $display("FAIL b2b_ack: got valid %b ov %b expected 0 0", valid_n, ov_n);
    end
  endtask

  task automatic test_random();
    bit sel, got;
    logic [7:0] d;
    logic p, stop;
    word_t e;
    for (int k = 0; k < 16; k++) begin
      sel  = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      p    = sel ? ((^d) ^ 1'($urandom_range(0, 3) == 0)) : 1'b0;
      stop = 1'($urandom_range(0, 5) != 0);
      e    = model(sel, d, p, stop);
      send_frame(sel, d, p, stop);
      wait_valid(sel, 2 * C, got);
      checks++;
      if (!got) begin errors++; $display("FAIL rand_valid[%0d]: got no rx_valid expected 1", k); end
      else if (obs(sel) !== e) begin
        errors++; $display("FAIL rand_word[%0d]: got %h expected %h (sel %0d)", k, obs(sel), e, sel);
      end
      pulse_ack(sel);
    end
  endtask

  initial begin
    test_reset();
    test_8n1_latency();
    test_parity();
    test_frame_error();
    test_break();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver and successor to the fixed 8N1 `uart_rx`. It adds:
- configurable data width, parity and stop-bit count;
- an input synchroniser with 3-sample majority voting and start-bit glitch rejection;
- break detection;
- a valid/ack output handshake with overrun reporting.

It sits between the external serial pin and the UART register/FIFO layer.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10: clock cycles per bit. Legal values are ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5–9, sent LSB first.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle level is high.
- `rx_data`  out  DATA_BITS  received word; stable while `rx_valid` is high.
- `rx_valid`  out  1  word available.
- `rx_ack`  in  1  consumer accepts the word; only meaningful while `rx_valid` is high.
- `frame_error`  out  1  a stop bit was sampled low. Qualified by `rx_valid`.
- `parity_error`  out  1  parity mismatch. Qualified by `rx_valid`; always 0 when `PARITY` = 0.
- `break_det`  out  1  break condition. Qualified by `rx_valid`.
- `overrun`  out  1  sticky flag: a word was dropped because the output was full.

## Operation
- **Input conditioning.** `rx` passes through a 2-flop synchroniser to give `rx_s`. `rx_s` feeds a 3-bit history shift register. A bit value is the majority of the 3 most recent `rx_s` samples.
- **Bit counter.** `cnt` counts 0..`CLKS_PER_BIT`-1. The sample point is `cnt` == `CLKS_PER_BIT`/2 (integer division).
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when `rx_s` = 0, clear `cnt` and go to START.
  - START: at the sample point, majority = 0 → DATA with bit index 0. Majority = 1 → IDLE (glitch rejected; no flags, no output).
  - DATA: sample bit[idx] into the shift register each bit period. After bit `DATA_BITS`-1, go to PARITY if `PARITY` ≠ 0, else STOP.
  - PARITY: sample the parity bit. Odd mode requires the XOR of data and parity = 1; even mode requires it = 0.
  - STOP: sample each of `STOP_BITS` stop bits. Any stop bit sampled 0 sets the frame error. At the last stop sample the frame completes; go to IDLE if `rx_s` = 1, else WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. A start is never detected on a line that is still low.
- **Break.** All data bits 0, parity bit 0 (if present) and first stop bit 0 → `break_det` = 1 and `frame_error` = 1 in the same word.
- **Frame completion with output empty** (`rx_valid` = 0, or `rx_ack` = 1 in the same cycle):
  - load `rx_data` and the three error flags;
  - set `rx_valid` on the next cycle.
- **Frame completion with output full** (`rx_valid` = 1 and `rx_ack` = 0):
  - discard the new word;
  - set `overrun`;
  - `rx_data` and its flags are held unchanged.
- **Handshake.** `rx_valid` stays high until a cycle with `rx_ack` = 1, which clears it on the next cycle. `overrun` clears on that same accepting cycle. Simultaneous ack and completion is a legal back-to-back handoff.

## Timing
- Reset values:
  - outputs: `rx_data` = 0, `rx_valid` = 0, all flags = 0;
  - internal: state = IDLE, synchroniser and history = all 1s, `cnt` = 0.
- Reset mid-frame aborts the frame and produces no output.
- Let t0 be the first cycle with `rx_s` = 0 (2 clocks after the `rx` edge).
  - Bit k (start bit = k = 0) is decided at t0 + `CLKS_PER_BIT`/2 + k·`CLKS_PER_BIT`.
  - `rx_valid` rises 1 cycle after the last stop-bit decision.
- The receiver tolerates ±4 % baud mismatch at `CLKS_PER_BIT` ≥ 8.
- Minimum idle between frames is 0: a start edge following the stop-bit sample point is accepted.

## Structure
- Shared package `uart_pkg` holds:
  - `parity_e` (NONE, ODD, EVEN);
  - `rx_state_e`;
  - the `PARITY_*` constants, reused by the matching transmitter.
- Sub-module `uart_rx_sync` holds the 2-flop synchroniser and the 3-tap majority filter. Outputs: `rx_s`, `rx_maj`.
- Elaboration-time assertions check the parameter ranges.

## Test plan
All cases use `CLKS_PER_BIT` = 10 unless stated.
- **8N1, 0xA5 then 0x3C, ack within 5 cycles** → `rx_data` = 0xA5, then 0x3C. `rx_valid` rises 1 cycle after each stop decision. All flags 0.
- **8E1, 0x3C with parity bit 1 (wrong)** → `rx_data` = 0x3C, `parity_error` = 1. A following 0x3C with parity bit 0 gives `parity_error` = 0.
- **8N1, 0xFF with stop bit held low for 1 bit, then high** → `frame_error` = 1, `break_det` = 0. Next frame 0x55 is received cleanly.
- **Line low for 20 bit times** → one word: `rx_data` = 0x00, `frame_error` = 1, `break_det` = 1. No further `rx_valid` until the line returns high and a new start bit arrives.
- **Two cases:**
  - a 3-cycle low glitch on an idle line → no `rx_valid`, state returns to IDLE;
  - `reset` asserted during DATA of 0x5A → no output, and the next frame 0x81 is received correctly.
- **Back-to-back 0x11, 0x22 with no ack** → `rx_data` stays 0x11 and `overrun` = 1. Ack clears `rx_valid` and `overrun` on the next cycle.
